// File: rtl/cmp_pkg.sv
// Shared types and constants for the 4-bit comparator operand loader.
package cmp_pkg;

  localparam int unsigned OperandW = 4;
  localparam int unsigned SelectW  = 2;

  localparam logic [SelectW-1:0] SEL_EQ  = 2'b00;
  localparam logic [SelectW-1:0] SEL_GR  = 2'b01;
  localparam logic [SelectW-1:0] SEL_LT  = 2'b10;
  localparam logic [SelectW-1:0] SEL_MAX = 2'b11;

  typedef enum logic [2:0] {
    StLoadX,
    StLoadY,
    StLoadOp,
    StEval,
    StHold
  } state_e;

  // True in the three states that consume input beats.
  function automatic logic is_load_state(input state_e st);
    return (st == StLoadX) || (st == StLoadY) || (st == StLoadOp);
  endfunction

endpackage

// File: rtl/cmp_txn_counter.sv
// Wrapping transaction counter; only instantiated when CMP_LOADER_COUNT_EN is defined.
module cmp_txn_counter
  import cmp_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  output logic [OperandW-1:0] count_o
);

  logic [OperandW-1:0] count_q, count_d;

  // Next count: wraps naturally from all-ones to zero.
  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cmp_operand_loader.sv
// Beat-stream sequencer feeding X, Y and Select to an external 4-bit comparator and
// returning its output over a valid/ready handshake, one transaction at a time.
// Optional: define CMP_LOADER_COUNT_EN to add the Count port (completed transactions).
module cmp_operand_loader
  import cmp_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OperandW-1:0] InData,
  input  logic                InValid,
  output logic                InReady,
  output logic [OperandW-1:0] X,
  output logic [OperandW-1:0] Y,
  output logic [SelectW-1:0]  Select,
  input  logic [OperandW-1:0] CmpOut,
  output logic [OperandW-1:0] Result,
  output logic                ResultValid,
  input  logic                ResultReady,
  output logic                Busy
`ifdef CMP_LOADER_COUNT_EN
  ,
  output logic [OperandW-1:0] Count
`endif
);

  state_e              state_q, state_d;
  logic [OperandW-1:0] x_q, x_d;
  logic [OperandW-1:0] y_q, y_d;
  logic [SelectW-1:0]  sel_q, sel_d;
  logic [OperandW-1:0] result_q, result_d;
  logic                beat_acc;

  assign beat_acc = InValid && is_load_state(state_q);

  // Next-state and register-update logic; each register moves only on its own event.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sel_d    = sel_q;
    result_d = result_q;
    unique case (state_q)
      StLoadX: begin
        if (beat_acc) begin
          x_d     = InData;
          state_d = StLoadY;
        end
      end
      StLoadY: begin
        if (beat_acc) begin
          y_d     = InData;
          state_d = StLoadOp;
        end
      end
      StLoadOp: begin
        if (beat_acc) begin
          sel_d   = InData[SelectW-1:0];
          state_d = StEval;
        end
      end
      StEval: begin
        // Operands have been stable for this whole cycle, so CmpOut is settled.
        result_d = CmpOut;
        state_d  = StHold;
      end
      StHold: begin
        if (ResultReady) state_d = StLoadX;
      end
      default: state_d = StLoadX;
    endcase
  end

  // State and datapath registers; Reset wins over any simultaneous beat or handshake.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StLoadX;
      x_q      <= '0;
      y_q      <= '0;
      sel_q    <= SEL_EQ;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  assign InReady     = is_load_state(state_q);
  assign Busy        = (state_q != StLoadX);
  assign ResultValid = (state_q == StHold);
  assign X           = x_q;
  assign Y           = y_q;
  assign Select      = sel_q;
  assign Result      = result_q;

`ifdef CMP_LOADER_COUNT_EN
  logic result_hs;
  assign result_hs = (state_q == StHold) && ResultReady;

  cmp_txn_counter u_txn_counter (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .inc_i   (result_hs),
    .count_o (Count)
  );
`endif

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Directed, table-driven bench for cmp_operand_loader with a behavioural comparator.
module tb_cmp_operand_loader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] InData;
  logic       InValid;
  logic       InReady;
  logic [3:0] X, Y;
  logic [1:0] Select;
  logic [3:0] CmpOut;
  logic [3:0] Result;
  logic       ResultValid;
  logic       ResultReady;
  logic       Busy;
`ifdef CMP_LOADER_COUNT_EN
  logic [3:0] Count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  cmp_operand_loader dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InData      (InData),
    .InValid     (InValid),
    .InReady     (InReady),
    .X           (X),
    .Y           (Y),
    .Select      (Select),
    .CmpOut      (CmpOut),
    .Result      (Result),
    .ResultValid (ResultValid),
    .ResultReady (ResultReady),
    .Busy        (Busy)
`ifdef CMP_LOADER_COUNT_EN
    ,
    .Count       (Count)
`endif
  );

  // Behavioural comparator driven by the loader outputs.
  always_comb begin
    CmpOut = 4'd0;
    case (Select)
      2'b00:   CmpOut = {3'b000, X == Y};
      2'b01:   CmpOut = {3'b000, X > Y};
      2'b10:   CmpOut = {3'b000, X < Y};
      default: CmpOut = (X > Y) ? X : Y;
    endcase
  end

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] op;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic beat(input logic [3:0] d);
    int n = 0;
    @(negedge Clock);
    InData  = d;
    InValid = 1'b1;
    while (!InReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!InReady) check("beat_timeout", 8'd0, 8'd1);
    @(posedge Clock);
    #1 InValid = 1'b0;
  endtask

  task automatic handshake();
    @(negedge Clock);
    ResultReady = 1'b1;
    @(posedge Clock);
    #1 ResultReady = 1'b0;
  endtask

  // Full transaction with latency and result checks; returns in LOAD_X.
  task automatic run_txn(input vec_t v);
    beat(v.x);
    beat(v.y);
    beat(v.op);
    @(negedge Clock);  // cycle N+1: EVAL
    check("eval_busy", {7'd0, Busy}, 8'd1);
    check("eval_inready", {7'd0, InReady}, 8'd0);
    check("eval_rvalid", {7'd0, ResultValid}, 8'd0);
    check("eval_select", {6'd0, Select}, {6'd0, v.op[1:0]});
    @(negedge Clock);  // cycle N+2: HOLD
    check("hold_rvalid", {7'd0, ResultValid}, 8'd1);
    check("hold_result", {4'd0, Result}, {4'd0, v.exp});
    handshake();
    @(negedge Clock);
    check("post_hs_rvalid", {7'd0, ResultValid}, 8'd0);
    check("post_hs_busy", {7'd0, Busy}, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{x: 4'd5,  y: 4'd9,  op: 4'd3, exp: 4'd9};
    vecs[1] = '{x: 4'd7,  y: 4'd7,  op: 4'd0, exp: 4'd1};
    vecs[2] = '{x: 4'd12, y: 4'd3,  op: 4'd1, exp: 4'd1};
    vecs[3] = '{x: 4'd12, y: 4'd3,  op: 4'd2, exp: 4'd0};
    vecs[4] = '{x: 4'd3,  y: 4'd12, op: 4'd2, exp: 4'd1};
    vecs[5] = '{x: 4'd3,  y: 4'd12, op: 4'd7, exp: 4'd12};  // bits [3:2] ignored
    vecs[6] = '{x: 4'd0,  y: 4'd0,  op: 4'd1, exp: 4'd0};
    vecs[7] = '{x: 4'd15, y: 4'd14, op: 4'd3, exp: 4'd15};

    Reset = 1'b1; InData = 4'd0; InValid = 1'b0; ResultReady = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_inready", {7'd0, InReady}, 8'd1);
    check("rst_busy", {7'd0, Busy}, 8'd0);
    check("rst_rvalid", {7'd0, ResultValid}, 8'd0);
    check("rst_x", {4'd0, X}, 8'd0);
    check("rst_y", {4'd0, Y}, 8'd0);
    check("rst_sel", {6'd0, Select}, 8'd0);
    check("rst_result", {4'd0, Result}, 8'd0);
`ifdef CMP_LOADER_COUNT_EN
    check("rst_count", {4'd0, Count}, 8'd0);
`endif

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Backpressure: result held, no beats consumed while InValid stays high.
    beat(4'd4); beat(4'd6); beat(4'd3);
    @(negedge Clock);
    InData = 4'hA; InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("bp_result", {4'd0, Result}, 8'd6);
      check("bp_rvalid", {7'd0, ResultValid}, 8'd1);
      check("bp_inready", {7'd0, InReady}, 8'd0);
      check("bp_x", {4'd0, X}, 8'd4);
    end
    InValid = 1'b0;
    ResultReady = 1'b1;
    @(posedge Clock);
    #1 ResultReady = 1'b0;
    @(negedge Clock);
    check("bp_release_inready", {7'd0, InReady}, 8'd1);
    check("bp_release_rvalid", {7'd0, ResultValid}, 8'd0);
    check("bp_release_x", {4'd0, X}, 8'd4);

    // Stalls: valid toggles every cycle; junk data on idle cycles must not land.
    @(negedge Clock); InData = 4'd2; InValid = 1'b1;
    @(negedge Clock); InData = 4'd9; InValid = 1'b0;
    check("stall_x", {4'd0, X}, 8'd2);
    @(negedge Clock); InData = 4'd1; InValid = 1'b1;
    @(negedge Clock); InData = 4'd7; InValid = 1'b0;
    check("stall_y", {4'd0, Y}, 8'd1);
    check("stall_busy_op", {7'd0, InReady}, 8'd1);
    @(negedge Clock); InData = 4'd1; InValid = 1'b1;
    @(negedge Clock); InValid = 1'b0;
    check("stall_eval_sel", {6'd0, Select}, 8'd1);
    check("stall_eval_inready", {7'd0, InReady}, 8'd0);
    @(negedge Clock);
    check("stall_result", {4'd0, Result}, 8'd1);
    check("stall_rvalid", {7'd0, ResultValid}, 8'd1);
    handshake();

    // Reset after X accepted: partial operand discarded.
    beat(4'd8);
    do_reset();
    check("midrst_x", {4'd0, X}, 8'd0);
    check("midrst_busy", {7'd0, Busy}, 8'd0);
    v = '{x: 4'd2, y: 4'd1, op: 4'd1, exp: 4'd1};
    beat(v.x);
    check("midrst_x_new", {4'd0, X}, 8'd2);
    beat(v.y); beat(v.op);
    repeat (2) @(negedge Clock);
    check("midrst_result", {4'd0, Result}, 8'd1);
    check("midrst_x_final", {4'd0, X}, 8'd2);
    // Reset in HOLD with ResultReady high: result lost, Reset wins.
    @(negedge Clock);
    Reset = 1'b1; ResultReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0; ResultReady = 1'b0;
    check("hold_rst_rvalid", {7'd0, ResultValid}, 8'd0);
    check("hold_rst_result", {4'd0, Result}, 8'd0);
    check("hold_rst_inready", {7'd0, InReady}, 8'd1);

`ifdef CMP_LOADER_COUNT_EN
    do_reset();
    check("cnt_clear", {4'd0, Count}, 8'd0);
    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i % 8]);
      if (i == 14) check("cnt_15", {4'd0, Count}, 8'd15);
      if (i == 15) check("cnt_wrap", {4'd0, Count}, 8'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmp_operand_loader.md
# cmp_operand_loader

Upstream sequencer for the 4-bit comparison unit (EQ/GR/LT/MAX). It accepts a stream of 4-bit beats carrying X, then Y, then an opcode. It drives registered, stable X/Y/Select into the combinational comparator and captures the comparator's 4-bit output one cycle later. It returns that output through a valid/ready result handshake, one transaction at a time.

## Interface
Parameters:
- none (widths fixed: operand 4 bits, select 2 bits)

Ports:
- Clock  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high
- InData  input  4  beat payload (X, then Y, then opcode in bits [1:0])
- InValid  input  1  beat valid
- InReady  output  1  loader can accept a beat
- X  output  4  operand X to comparator
- Y  output  4  operand Y to comparator
- Select  output  2  comparator opcode: 00 EQ, 01 GR, 10 LT, 11 MAX
- CmpOut  input  4  comparator result (EQ/GR/LT in bit 0, upper bits 0; MAX full 4 bits)
- Result  output  4  captured comparator result
- ResultValid  output  1  Result holds a completed transaction
- ResultReady  input  1  consumer accepts Result
- Busy  output  1  high in any state other than LOAD_X
- Count  output  4  completed-transaction counter (present only with CMP_LOADER_COUNT_EN)

## Operation
- The FSM has five states: LOAD_X, LOAD_Y, LOAD_OP, EVAL, HOLD. Reset state is LOAD_X.
- A beat is accepted when InValid && InReady. InReady is 1 only in the LOAD_X, LOAD_Y and LOAD_OP states.
- **LOAD_X**: an accepted beat writes InData to the X register; the FSM moves to LOAD_Y.
- **LOAD_Y**: an accepted beat writes InData to the Y register; the FSM moves to LOAD_OP.
- **LOAD_OP**: an accepted beat writes InData[1:0] to Select and ignores InData[3:2]; the FSM moves to EVAL.
- **EVAL**: one cycle. X, Y and Select are stable, and CmpOut is sampled into Result at the end of the cycle. The FSM moves to HOLD.
- **HOLD**: ResultValid=1. On ResultReady=1 the FSM moves to LOAD_X and ResultValid drops on the next cycle.
- If InValid is low in any LOAD state, the FSM waits with no change.
- X, Y and Select change only when their own beat is accepted. They keep their values through EVAL, HOLD and the start of the next transaction.
- Result changes only at the end of EVAL. It stays stable throughout HOLD regardless of ResultReady.
- ResultValid never drops without a handshake, except on Reset.

## Timing
- Reset values: state LOAD_X, X=0, Y=0, Select=00, Result=0, ResultValid=0, Busy=0, InReady=1, Count=0.
- Latency: if the opcode beat is accepted in cycle N, the FSM is in EVAL in cycle N+1 and ResultValid=1 from cycle N+2.
- Throughput: at least 5 cycles per transaction (3 beats, EVAL, 1 HOLD cycle with ResultReady high).
- No beat is accepted in EVAL or HOLD; InReady=0 in both.
- Reset mid-transaction: partial operands are discarded and the FSM returns to LOAD_X next cycle. A pending result is lost, with no handshake.
- Reset has priority over every simultaneous beat or result handshake.
- Select is used exactly as loaded. All four codes are legal, so there is no error path.

## Configuration
- Macro: CMP_LOADER_COUNT_EN.
- Defined:
  - The Count port exists: a 4-bit counter incremented on each result handshake (HOLD && ResultReady).
  - It wraps 15→0 and is cleared by Reset.
- Undefined:
  - The Count port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package cmp_pkg holds:
  - the FSM state enum (LOAD_X, LOAD_Y, LOAD_OP, EVAL, HOLD);
  - Select constants SEL_EQ=2'b00, SEL_GR=2'b01, SEL_LT=2'b10, SEL_MAX=2'b11;
  - the operand width constant 4.
- One sub-module is natural: cmp_txn_counter, the wrapping 4-bit counter, instantiated only under CMP_LOADER_COUNT_EN.
- The comparator is instantiated by the parent, not inside this block.

## Test plan
- **MAX:** beats 5, 9, 3 with ResultReady=1 → Select=11 in EVAL; Result=9, ResultValid=1 exactly 2 cycles after the opcode beat.
- **EQ, GR, LT:**
  - beats 7, 7, 0 → Result=1.
  - beats 12, 3, 1 → Result=1.
  - beats 12, 3, 2 → Result=0.
- **Backpressure:** complete beats 4, 6, 3, then hold ResultReady=0 for 3 cycles with InValid=1 → Result stays 6, ResultValid=1, InReady=0 and no beats consumed. Raising ResultReady → LOAD_X next cycle.
- **Stalls:** InValid toggles 1/0 every cycle during beats 2, 1, 1 → each beat captured only on valid cycles; Result=1.
- **Reset mid-operation:** accept X=8, assert Reset 1 cycle, then beats 2, 1, 1 → X=2, Result=1, and no stale X=8 is visible.
- **Counter wrap (CMP_LOADER_COUNT_EN):** run 16 back-to-back transactions → Count reads 15 after the 15th handshake and 0 after the 16th.
